// File: rtl/operand_extend_buf_pkg.sv
// Shared definitions for the multiplier-front operand blocks.
package operand_extend_buf_pkg;

    // Extension mode carried alongside each operand.
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ext_state_t;

endpackage

// File: rtl/operand_extend_buf_if.sv
// Operand handshake bundle: input side (source -> buffer) and output side (buffer -> multiplier).
interface operand_extend_buf_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_sext;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_neg;

    // Environment side: produces operands and consumes results.
    modport master (
        output in_valid,
        output in_data,
        output in_sext,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_neg
    );

    // Buffer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sext,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_neg
    );

endinterface

// File: rtl/operand_extend_buf_extend_core.sv
// Combinational zero/sign extension of one operand from IN_W to OUT_W bits.
module operand_extend_buf_extend_core
    import operand_extend_buf_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_sext_i,
    output logic [OUT_W-1:0] ext_data_o,
    output logic             neg_o
);

    logic fill_bit;

    // Upper bits are copies of the MSB only for a sign-extended negative operand.
    assign fill_bit = (in_sext_i == EXT_SIGN) && in_data_i[IN_W-1];
    assign neg_o    = fill_bit;

    if (OUT_W < IN_W) begin : g_bad_width
        $error("operand_extend_buf: OUT_W must be >= IN_W");
        assign ext_data_o = '0;
    end else if (OUT_W == IN_W) begin : g_pass
        assign ext_data_o = in_data_i;
    end else begin : g_extend
        assign ext_data_o = {{(OUT_W - IN_W){fill_bit}}, in_data_i};
    end

endmodule

// File: rtl/operand_extend_buf.sv
// Registered operand extender with a 2-entry skid buffer (main reg M, skid reg S).
module operand_extend_buf
    import operand_extend_buf_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    operand_extend_buf_if.slave  bus
);

    ext_state_t       state_q, state_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic             m_neg_q, m_neg_d;
    logic [OUT_W-1:0] s_data_q, s_data_d;
    logic             s_neg_q, s_neg_d;
    logic             in_ready_q, in_ready_d;

    logic [OUT_W-1:0] ext_data;
    logic             ext_neg;
    logic             in_acc;
    logic             out_acc;

    // Extend on the input side so the result is registered with no extra latency.
    operand_extend_buf_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_extend_core (
        .in_data_i  (bus.in_data),
        .in_sext_i  (bus.in_sext),
        .ext_data_o (ext_data),
        .neg_o      (ext_neg)
    );

    assign in_acc        = bus.in_valid && in_ready_q;
    assign out_acc       = (state_q != EMPTY) && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = m_data_q;
    assign bus.out_neg   = m_neg_q;

    // Next-state, register loads and registered in_ready; flush overrides every handshake.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_neg_d  = m_neg_q;
        s_data_d = s_data_q;
        s_neg_d  = s_neg_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_acc) begin
                        m_data_d = ext_data;
                        m_neg_d  = ext_neg;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        // New operand replaces the departing one, no bubble.
                        m_data_d = ext_data;
                        m_neg_d  = ext_neg;
                    end else if (in_acc) begin
                        s_data_d = ext_data;
                        s_neg_d  = ext_neg;
                        state_d  = FULL;
                    end else if (out_acc) begin
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_acc) begin
                        m_data_d = s_data_q;
                        m_neg_d  = s_neg_q;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != FULL);
    end

    // State and data registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            m_data_q   <= '0;
            m_neg_q    <= 1'b0;
            s_data_q   <= '0;
            s_neg_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_neg_q    <= m_neg_d;
            s_data_q   <= s_data_d;
            s_neg_q    <= s_neg_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
